// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access-size codes,
// FSM state encoding, timeout default and the access legality rule.
`timescale 1ns/1ps
package mem_stage_lsu_pkg;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Unsigned sizes exist only for loads; halfwords and words must be naturally aligned.
    function automatic logic rw_legal(input logic [2:0] rw_type,
                                      input logic [1:0] off,
                                      input logic       is_store);
        logic ok;
        ok = 1'b0;
        case (rw_type)
            RW_B:    ok = 1'b1;
            RW_BU:   ok = ~is_store;
            RW_H:    ok = ~off[0];
            RW_HU:   ok = ~is_store & ~off[0];
            RW_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension
// for loads. Purely combinational; the two paths are independent.
`timescale 1ns/1ps
module lsu_lane_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  st_type,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_lane_wdata,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted_s;

    // Store path: replicate the datum across every lane so the slave only needs the enables.
    always_comb begin
        st_be         = 4'b0000;
        st_lane_wdata = 32'h0000_0000;
        case (st_type)
            RW_B, RW_BU: begin
                st_be         = 4'b0001 << st_off;
                st_lane_wdata = {4{st_wdata[7:0]}};
            end
            RW_H, RW_HU: begin
                st_be         = st_off[1] ? 4'b1100 : 4'b0011;
                st_lane_wdata = {2{st_wdata[15:0]}};
            end
            RW_W: begin
                st_be         = 4'b1111;
                st_lane_wdata = st_wdata;
            end
            default: begin
                st_be         = 4'b0000;
                st_lane_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend to a full word.
    always_comb begin
        shifted_s = ld_rdata >> {ld_off, 3'b000};
        ld_data   = 32'h0000_0000;
        case (ld_type)
            RW_B:    ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            RW_BU:   ld_data = {24'h00_0000, shifted_s[7:0]};
            RW_H:    ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            RW_HU:   ld_data = {16'h0000, shifted_s[15:0]};
            RW_W:    ld_data = shifted_s;
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store responder: runs EX/MEM accesses on a req/ack word bus,
// stalls the front of the pipeline while a transaction is outstanding.
`timescale 1ns/1ps
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  RW_type_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        stall_o,
    output logic        fault_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_r;
    logic [7:0]  cnt_r;
    logic [29:0] addr_r;
    logic [1:0]  off_r;
    logic [2:0]  type_r;
    logic        we_r;
    logic [3:0]  be_r;
    logic [31:0] wdata_r;
    logic        bus_req_r;
    logic [31:0] load_data_r;
    logic        load_valid_r;
    logic        fault_r;
    logic        stall_s;

    logic        access_s;
    logic        legal_s;
    logic [3:0]  st_be_s;
    logic [31:0] st_wdata_s;
    logic [31:0] ld_data_s;

    assign access_s = MemRead_i | MemWrite_i;
    // A simultaneous read and write is treated as a store.
    assign legal_s  = rw_legal(RW_type_i, addr_i[1:0], MemWrite_i);

    lsu_lane_align u_lane_align (
        .st_type       (RW_type_i),
        .st_off        (addr_i[1:0]),
        .st_wdata      (wdata_i),
        .st_be         (st_be_s),
        .st_lane_wdata (st_wdata_s),
        .ld_type       (type_r),
        .ld_off        (off_r),
        .ld_rdata      (bus_rdata_i),
        .ld_data       (ld_data_s)
    );

    // Sequencer: accept in IDLE, hold the bus in REQ until ack or timeout, report in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            addr_r       <= 30'd0;
            off_r        <= 2'b00;
            type_r       <= 3'b000;
            we_r         <= 1'b0;
            be_r         <= 4'b0000;
            wdata_r      <= 32'h0000_0000;
            bus_req_r    <= 1'b0;
            load_data_r  <= 32'h0000_0000;
            load_valid_r <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            load_valid_r <= 1'b0;
            fault_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (access_s && legal_s) begin
                        addr_r    <= addr_i[31:2];
                        off_r     <= addr_i[1:0];
                        type_r    <= RW_type_i;
                        we_r      <= MemWrite_i;
                        be_r      <= st_be_s;
                        wdata_r   <= MemWrite_i ? st_wdata_s : 32'h0000_0000;
                        cnt_r     <= 8'd0;
                        bus_req_r <= 1'b1;
                        state_r   <= ST_REQ;
                    end else if (access_s) begin
                        fault_r   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus_ack_i) begin
                        bus_req_r    <= 1'b0;
                        load_valid_r <= ~we_r;
                        load_data_r  <= we_r ? 32'h0000_0000 : ld_data_s;
                        state_r      <= ST_DONE;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        // Abandon the transfer; the slave tolerates a dropped request.
                        bus_req_r    <= 1'b0;
                        load_data_r  <= 32'h0000_0000;
                        fault_r      <= 1'b1;
                        state_r      <= ST_DONE;
                    end else begin
                        cnt_r        <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    bus_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall covers the accepting IDLE cycle and every REQ cycle; reset forces it low at once.
    always_comb begin
        stall_s = 1'b0;
        if (!rst_n) begin
            stall_s = 1'b0;
        end else if (state_r == ST_REQ) begin
            stall_s = 1'b1;
        end else if (state_r == ST_IDLE) begin
            stall_s = access_s & legal_s;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign stall_o      = stall_s;
    assign bus_req_o    = bus_req_r;
    assign bus_we_o     = we_r;
    assign bus_addr_o   = {addr_r, 2'b00};
    assign bus_be_o     = be_r;
    assign bus_wdata_o  = wdata_r;
    assign load_data_o  = load_data_r;
    assign load_valid_o = load_valid_r;
    assign fault_o      = fault_r;

endmodule
